// File: rtl/demultiplexer2_buf.sv
// Two-way demultiplexer with a 2-entry FIFO per output.
// Each output has a registered head and a delivered-word counter.
module demultiplexer2_buf #(
    parameter int w  = 8,
    parameter int cw = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          selector,
    input  logic [w-1:0]  data_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [w-1:0]  data_out_0,
    output logic          out_valid_0,
    input  logic          out_ready_0,
    output logic [w-1:0]  data_out_1,
    output logic          out_valid_1,
    input  logic          out_ready_1,
    output logic [cw-1:0] count_0,
    output logic [cw-1:0] count_1
);

    logic [w-1:0]  head [2];
    logic [w-1:0]  tail [2];
    logic [1:0]    occ  [2];
    logic [cw-1:0] cnt  [2];

    logic [1:0] out_rdy;
    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;

    assign out_rdy = {out_ready_1, out_ready_0};

    // Handshake decode: admission looks only at the selected FIFO's occupancy.
    always_comb begin
        full     = 2'b00;
        push     = 2'b00;
        pop      = 2'b00;
        in_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            full[i] = (occ[i] == 2'd2);
        end
        in_ready = reset && !full[selector];
        for (int i = 0; i < 2; i++) begin
            push[i] = in_valid && in_ready && (selector == 1'(i));
            pop[i]  = (occ[i] != 2'd0) && out_rdy[i];
        end
    end

    // Per-output FIFO storage, occupancy and delivered-word counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                head[i] <= '0;
                tail[i] <= '0;
                occ[i]  <= 2'd0;
                cnt[i]  <= '0;
            end else begin
                if (pop[i]) begin
                    cnt[i] <= cnt[i] + cw'(1);
                end
                if (push[i] && pop[i]) begin
                    if (occ[i] == 2'd2) begin
                        head[i] <= tail[i];
                        tail[i] <= data_in;
                    end else begin
                        head[i] <= data_in;
                    end
                end else if (pop[i]) begin
                    if (occ[i] == 2'd2) begin
                        head[i] <= tail[i];
                    end
                    occ[i] <= occ[i] - 2'd1;
                end else if (push[i]) begin
                    if (occ[i] == 2'd0) begin
                        head[i] <= data_in;
                    end else begin
                        tail[i] <= data_in;
                    end
                    occ[i] <= occ[i] + 2'd1;
                end
            end
        end
    end

    assign data_out_0  = head[0];
    assign data_out_1  = head[1];
    assign out_valid_0 = (occ[0] != 2'd0);
    assign out_valid_1 = (occ[1] != 2'd0);
    assign count_0     = cnt[0];
    assign count_1     = cnt[1];

endmodule

// File: tb/tb_demultiplexer2_buf.sv
// Bench for demultiplexer2_buf: directed scenarios plus random traffic
// checked against a queue-based model of the two output FIFOs.
module tb_demultiplexer2_buf;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sel;
    logic [W-1:0]  din;
    logic          iv;
    logic          ir;
    logic [W-1:0]  d0, d1;
    logic          v0, v1;
    logic          r0, r1;
    logic [CW-1:0] c0, c1;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    always #5 clk = ~clk;

    demultiplexer2_buf #(.w(W), .cw(CW)) dut (
        .clk(clk), .reset(rst_n), .selector(sel), .data_in(din),
        .in_valid(iv), .in_ready(ir),
        .data_out_0(d0), .out_valid_0(v0), .out_ready_0(r0),
        .data_out_1(d1), .out_valid_1(v1), .out_ready_1(r1),
        .count_0(c0), .count_1(c1)
    );

    task automatic drive(input logic rn, input logic v, input logic s,
                         input logic [W-1:0] d, input logic a0, input logic a1);
        rst_n = rn; iv = v; sel = s; din = d; r0 = a0; r1 = a1;
        #1;
    endtask

    // Advance one clock edge and update the reference queues.
    task automatic tick();
        bit acc, p0, p1;
        int sz;
        sz  = sel ? q1.size() : q0.size();
        acc = rst_n && iv && (sz < 2);
        p0  = (q0.size() != 0) && r0;
        p1  = (q1.size() != 0) && r1;
        @(posedge clk);
        if (!rst_n) begin
            q0.delete(); q1.delete();
            m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            if (p0) begin void'(q0.pop_front()); m_cnt0 = (m_cnt0 + 1) % (1 << CW); end
            if (p1) begin void'(q1.pop_front()); m_cnt1 = (m_cnt1 + 1) % (1 << CW); end
            if (acc) begin
                if (sel) q1.push_back(din);
                else     q0.push_back(din);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, i[0], 8'hFF, 1, 1);
            checks++; if (ir !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", ir); end
            tick();
            checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b%b want 00", v1, v0); end
            checks++; if (c0 !== 0 || c1 !== 0) begin failures++; $display("FAIL reset_count: got %0d %0d want 0 0", c0, c1); end
            checks++; if (d0 !== 0 || d1 !== 0) begin failures++; $display("FAIL reset_data: got %h %h want 00 00", d0, d1); end
        end
        drive(1, 0, 0, 8'h00, 0, 0);
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b want 1", ir); end
        tick();
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL idle_in_ready: got %b want 1", ir); end
    endtask

    task automatic test_basic();
        drive(1, 1, 0, 8'hA5, 1, 1);
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL basic_ready0: got %b want 1", ir); end
        tick();
        checks++; if (v0 !== 1'b1 || d0 !== 8'hA5) begin failures++; $display("FAIL basic_out0: got v=%b d=%h want v=1 d=a5", v0, d0); end
        drive(1, 1, 1, 8'h3C, 1, 1);
        tick();
        checks++; if (v1 !== 1'b1 || d1 !== 8'h3C) begin failures++; $display("FAIL basic_out1: got v=%b d=%h want v=1 d=3c", v1, d1); end
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL basic_drain0: got %b want 0", v0); end
        drive(1, 0, 0, 8'h00, 1, 1);
        tick();
        checks++; if (c0 !== 4'd1 || c1 !== 4'd1) begin failures++; $display("FAIL basic_count: got %0d %0d want 1 1", c0, c1); end
    endtask

    task automatic test_full();
        drive(1, 1, 0, 8'h01, 0, 0);
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL full_acc1: got %b want 1", ir); end
        tick();
        drive(1, 1, 0, 8'h02, 0, 0);
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL full_acc2: got %b want 1", ir); end
        tick();
        drive(1, 1, 0, 8'h03, 0, 0);
        checks++; if (ir !== 1'b0) begin failures++; $display("FAIL full_block: got %b want 0", ir); end
        tick();
        drive(1, 1, 1, 8'h10, 0, 0);
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL full_isolation: got %b want 1", ir); end
        tick();
        checks++; if (v1 !== 1'b1 || d1 !== 8'h10) begin failures++; $display("FAIL full_out1: got v=%b d=%h want v=1 d=10", v1, d1); end
        drive(1, 1, 0, 8'h03, 1, 0);
        checks++; if (ir !== 1'b0) begin failures++; $display("FAIL full_no_passthru: got %b want 0", ir); end
        checks++; if (d0 !== 8'h01) begin failures++; $display("FAIL full_order1: got %h want 01", d0); end
        tick();
        drive(1, 1, 0, 8'h03, 1, 0);
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL full_reopen: got %b want 1", ir); end
        checks++; if (d0 !== 8'h02) begin failures++; $display("FAIL full_order2: got %h want 02", d0); end
        tick();
        drive(1, 0, 0, 8'h00, 1, 0);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h03) begin failures++; $display("FAIL full_order3: got v=%b d=%h want v=1 d=03", v0, d0); end
        tick();
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL full_empty: got %b want 0", v0); end
        checks++; if (c0 !== 4'd4 || v1 !== 1'b1) begin failures++; $display("FAIL full_count0: got c0=%0d v1=%b want c0=4 v1=1", c0, v1); end
    endtask

    task automatic test_concurrent();
        drive(1, 0, 0, 8'h00, 0, 1);
        tick();
        drive(1, 1, 1, 8'h11, 0, 0);
        tick();
        checks++; if (v1 !== 1'b1 || d1 !== 8'h11) begin failures++; $display("FAIL conc_head: got v=%b d=%h want v=1 d=11", v1, d1); end
        drive(1, 1, 1, 8'h22, 0, 1);
        checks++; if (ir !== 1'b1) begin failures++; $display("FAIL conc_ready: got %b want 1", ir); end
        tick();
        checks++; if (v1 !== 1'b1 || d1 !== 8'h22) begin failures++; $display("FAIL conc_after: got v=%b d=%h want v=1 d=22", v1, d1); end
        drive(1, 0, 0, 8'h00, 0, 0);
        tick();
        checks++; if (v1 !== 1'b1 || d1 !== 8'h22) begin failures++; $display("FAIL conc_hold: got v=%b d=%h want v=1 d=22", v1, d1); end
        drive(1, 0, 0, 8'h00, 0, 1);
        tick();
        checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL conc_occ1: got %b want 0", v1); end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 8'h00, 0, 0);
        tick();
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 0, 8'(i + 8'h40), 1, 0);
            tick();
        end
        drive(1, 0, 0, 8'h00, 1, 0);
        tick();
        checks++; if (c0 !== 4'd1 || c1 !== 4'd0) begin failures++; $display("FAIL wrap_count: got %0d %0d want 1 0", c0, c1); end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, i[0], 8'(8'h80 + i), 0, 0);
            tick();
        end
        checks++; if (v0 !== 1'b1 || v1 !== 1'b1) begin failures++; $display("FAIL mid_filled: got %b%b want 11", v1, v0); end
        drive(0, 1, 0, 8'h55, 1, 1);
        checks++; if (ir !== 1'b0) begin failures++; $display("FAIL mid_ready: got %b want 0", ir); end
        tick();
        checks++; if (v0 !== 1'b0 || v1 !== 1'b0 || c0 !== 0 || c1 !== 0) begin
            failures++; $display("FAIL mid_cleared: got v=%b%b c=%0d,%0d want v=00 c=0,0", v1, v0, c0, c1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 8'h00, 1, 1);
            tick();
            checks++; if (v0 !== 1'b0 || v1 !== 1'b0) begin failures++; $display("FAIL mid_ghost: got %b%b want 00", v1, v0); end
        end
    endtask

    task automatic test_random();
        bit exp_ir;
        for (int n = 0; n < 400; n++) begin
            drive(1, 1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
            exp_ir = (sel ? q1.size() : q0.size()) < 2;
            checks++; if (ir !== exp_ir) begin failures++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, ir, exp_ir); end
            checks++; if (v0 !== (q0.size() != 0) || v1 !== (q1.size() != 0)) begin
                failures++; $display("FAIL rnd_valid[%0d]: got %b%b want %b%b", n, v1, v0, q1.size() != 0, q0.size() != 0);
            end
            if (q0.size() != 0) begin
                checks++; if (d0 !== q0[0]) begin failures++; $display("FAIL rnd_data0[%0d]: got %h want %h", n, d0, q0[0]); end
            end
            if (q1.size() != 0) begin
                checks++; if (d1 !== q1[0]) begin failures++; $display("FAIL rnd_data1[%0d]: got %h want %h", n, d1, q1[0]); end
            end
            checks++; if (c0 !== 4'(m_cnt0) || c1 !== 4'(m_cnt1)) begin
                failures++; $display("FAIL rnd_count[%0d]: got %0d %0d want %0d %0d", n, c0, c1, m_cnt0, m_cnt1);
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; iv = 1'b0; sel = 1'b0; din = '0; r0 = 1'b0; r1 = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_concurrent();
        test_wrap();
        test_midreset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demultiplexer2_buf.md
Name: demultiplexer2_buf

Overview:
- Two-way demultiplexer: the inverse of the two-input selector mux used across the datapath.
- Accepts one valid/ready input stream and routes each word, by a per-word selector, to one of two output streams.
- Each output has a 2-entry FIFO, which decouples back-pressure between the two destinations. Example: vector-unit result writeback split between the register file and the memory path.
- Per-output word counters are provided for debug and performance monitoring.

Parameters:
- w, 8, data width in bits; legal range is w >= 1.
- cw, 16, width of each per-output transfer counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- selector  in  1  destination of the current input word: 0 = output 0, 1 = output 1. Qualified by in_valid.
- data_in  in  w  input word.
- in_valid  in  1  input word and selector are valid.
- in_ready  out  1  block can accept the input word this cycle.
- data_out_0  out  w  head word of FIFO 0.
- out_valid_0  out  1  FIFO 0 not empty.
- out_ready_0  in  1  consumer 0 accepts the head word.
- data_out_1  out  w  head word of FIFO 1.
- out_valid_1  out  1  FIFO 1 not empty.
- out_ready_1  in  1  consumer 1 accepts the head word.
- count_0  out  cw  number of words delivered on output 0.
- count_1  out  cw  number of words delivered on output 1.

Behaviour:
- Reset, while reset = 0 at a rising edge:
  - Both FIFOs are emptied.
  - out_valid_0 = out_valid_1 = 0.
  - count_0 = count_1 = 0.
  - data_out_0 and data_out_1 are 0.
  - in_ready is 0 during reset.
  - Reset applied mid-transfer discards all buffered words; no handshake completes in that cycle.
- Input handshake:
  - A transfer occurs on a cycle where in_valid = 1 and in_ready = 1.
  - in_ready = reset AND NOT full(FIFO[selector]).
  - in_ready is a combinational function of selector, reset and FIFO occupancy only. It never depends on out_ready_0 or out_ready_1.
  - A full destination does not admit a word in the same cycle it pops (no pass-through when full).
  - A full FIFO 0 never blocks a word with selector = 1, and vice versa.
- Routing: an accepted word is written to FIFO[selector] at the rising edge. Minimum latency from acceptance to out_valid_x = 1 is 1 cycle; there is no combinational in-to-out path.
- FIFO structure (per output x, identical):
  - 2 entries, with an occupancy counter in the range 0..2.
  - Head is registered: data_out_x always shows the oldest entry.
  - out_valid_x = (occupancy != 0).
- FIFO pop and push:
  - Pop when out_valid_x = 1 and out_ready_x = 1.
  - Push and pop in the same cycle at occupancy 1: occupancy stays at 1, and the newly pushed word becomes the head after the pop.
  - Push and pop in the same cycle at occupancy 0: a pop cannot occur, so occupancy becomes 1.
- Ordering: words on each output leave in acceptance order. There is no ordering relation between the two outputs.
- data_out_x when out_valid_x = 0 is don't-care for consumers; RTL holds the last head value.
- Output stability: while out_valid_x = 1 and out_ready_x = 0, data_out_x and out_valid_x hold.
- Counters:
  - count_x increments by 1 on each pop of FIFO x.
  - Counters wrap modulo 2^cw; all-ones + 1 = 0, with no saturation and no flag.
- Simultaneous events: both outputs may pop and the input may push in the same cycle; all three take effect at that edge.
- in_valid = 0: selector and data_in are ignored and no state changes.

Test Plan:
- Reset and idle: hold reset = 0 for 3 cycles with in_valid = 1 -> in_ready = 0, out_valid_0/1 = 0, count_0/1 = 0. Release reset -> in_ready = 1 next cycle.
- Basic routing (w = 8): send 0xA5 with selector = 0, then 0x3C with selector = 1, both out_ready = 1 -> data_out_0 = 0xA5 one cycle after acceptance, data_out_1 = 0x3C one cycle after its acceptance. count_0 = 1, count_1 = 1.
- Full and isolation:
  - Hold out_ready_0 = 0 and send 3 words to output 0 (0x01, 0x02, 0x03) -> in_ready drops after 2 accepts while 0x03 is presented.
  - Switch selector to 1 and send 0x10 -> accepted immediately, data_out_1 = 0x10.
  - Raise out_ready_0 -> outputs 0x01, 0x02, 0x03 in order.
- Concurrent push/pop: with FIFO 1 at occupancy 1 (head 0x11), push 0x22 while popping -> next cycle data_out_1 = 0x22, out_valid_1 = 1, occupancy = 1.
- Counter wrap (cw = 4): deliver 17 words on output 0 -> count_0 = 1, count_1 = 0.
- Mid-operation reset: both FIFOs at occupancy 2, assert reset for 1 cycle -> out_valid_0/1 = 0 and count_0/1 = 0 next cycle. No buffered word appears after reset is released.
